// File: rtl/p_islip_scheduler.sv
// Priority iSLIP crossbar scheduler: snapshots VOQ occupancy per slot and runs
// up to ITER request-grant-accept iterations. Optional statistics: P_ISLIP_SCHED_STATS_EN.
module p_islip_scheduler #(
  parameter int PORT      = 8,
  parameter int PRIORITY  = 4,
  parameter int ITER      = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [PORT*PORT*PRIORITY-1:0] i_voq_req,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [PORT*PORT-1:0]          o_match,
  output logic [PORT*PRIORITY-1:0]      o_match_pri,
  output logic [CNT_WIDTH-1:0]          o_match_cnt,
  output logic [CNT_WIDTH-1:0]          o_slot_cnt
);

  localparam int REQ_W = PORT * PORT * PRIORITY;
  localparam int PTR_W = (PORT > 1) ? $clog2(PORT) : 1;
  localparam int PRI_W = (PRIORITY > 1) ? $clog2(PRIORITY) : 1;
  localparam int IT_W  = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, GRANT, ACCEPT, DONE} state_t;

  state_t               state_q, state_d;
  logic [REQ_W-1:0]     req_r;
  logic [PORT-1:0]      in_matched, out_matched;
  logic [IT_W-1:0]      iter_cnt;
  logic                 last_iter;
  logic [PTR_W-1:0]     g_ptr [PORT][PRIORITY];
  logic [PTR_W-1:0]     a_ptr [PORT][PRIORITY];

  logic [PORT-1:0]      col_req [PORT][PRIORITY];   // [out][p], one bit per input
  logic [PORT-1:0]      gnt_v_d, gnt_v_r;
  logic [PTR_W-1:0]     gnt_in_d  [PORT];
  logic [PTR_W-1:0]     gnt_in_r  [PORT];
  logic [PRI_W-1:0]     gnt_pri_d [PORT];
  logic [PRI_W-1:0]     gnt_pri_r [PORT];

  logic [PORT-1:0]      row_gnt [PORT][PRIORITY];   // [in][p], one bit per output
  logic [PORT-1:0]      acc_v;
  logic [PTR_W-1:0]     acc_out [PORT];
  logic [PRI_W-1:0]     acc_pri [PORT];

  logic [PORT*PORT-1:0]     match_r;
  logic [PORT*PRIORITY-1:0] match_pri_r;

  // First set bit of vec at or after ptr, wrapping modulo PORT.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [PORT-1:0]  vec,
                                                input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < PORT; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && vec[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Requests seen by each output: only unmatched inputs towards unmatched outputs.
  always_comb begin
    for (int o = 0; o < PORT; o++)
      for (int p = 0; p < PRIORITY; p++)
        for (int i = 0; i < PORT; i++)
          col_req[o][p][i] = req_r[(i*PORT+o)*PRIORITY+p] & ~in_matched[i] & ~out_matched[o];
  end

  // Grant: descending scan so the lowest non-empty priority index wins.
  always_comb begin
    for (int o = 0; o < PORT; o++) begin
      gnt_v_d[o]   = 1'b0;
      gnt_in_d[o]  = '0;
      gnt_pri_d[o] = '0;
      for (int p = PRIORITY - 1; p >= 0; p--) begin
        if (|col_req[o][p]) begin
          gnt_v_d[o]   = 1'b1;
          gnt_pri_d[o] = PRI_W'(p);
          gnt_in_d[o]  = rr_pick(col_req[o][p], g_ptr[o][p]);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PORT; i++)
      for (int p = 0; p < PRIORITY; p++)
        for (int o = 0; o < PORT; o++)
          row_gnt[i][p][o] = gnt_v_r[o] && (gnt_in_r[o] == PTR_W'(i)) &&
                             (gnt_pri_r[o] == PRI_W'(p)) && !in_matched[i];
  end

  // Accept: same lowest-priority-first, round-robin-within-level rule per input.
  always_comb begin
    for (int i = 0; i < PORT; i++) begin
      acc_v[i]   = 1'b0;
      acc_out[i] = '0;
      acc_pri[i] = '0;
      for (int p = PRIORITY - 1; p >= 0; p--) begin
        if (|row_gnt[i][p]) begin
          acc_v[i]   = 1'b1;
          acc_pri[i] = PRI_W'(p);
          acc_out[i] = rr_pick(row_gnt[i][p], a_ptr[i][p]);
        end
      end
    end
  end

  assign last_iter = (iter_cnt == IT_W'(ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE:   if (i_start) state_d = GRANT;
      GRANT:  begin
        o_busy  = 1'b1;
        state_d = ACCEPT;
      end
      ACCEPT: begin
        o_busy  = 1'b1;
        state_d = (!(|acc_v) || last_iter) ? DONE : GRANT;
      end
      DONE:   begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r       <= '0;
      in_matched  <= '0;
      out_matched <= '0;
      iter_cnt    <= '0;
      match_r     <= '0;
      match_pri_r <= '0;
      gnt_v_r     <= '0;
      // NOTE: pointer arrays are small flop banks, not RAM, so they take reset;
      // a RAM-mapped array must never be reset this way.
      for (int n = 0; n < PORT; n++) begin
        gnt_in_r[n]  <= '0;
        gnt_pri_r[n] <= '0;
        for (int p = 0; p < PRIORITY; p++) begin
          g_ptr[n][p] <= '0;
          a_ptr[n][p] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          req_r       <= i_voq_req;
          in_matched  <= '0;
          out_matched <= '0;
          match_r     <= '0;
          match_pri_r <= '0;
          iter_cnt    <= IT_W'(1);
        end
        GRANT: begin
          gnt_v_r <= gnt_v_d;
          for (int o = 0; o < PORT; o++) begin
            gnt_in_r[o]  <= gnt_in_d[o];
            gnt_pri_r[o] <= gnt_pri_d[o];
          end
        end
        ACCEPT: begin
          for (int i = 0; i < PORT; i++) begin
            if (acc_v[i]) begin
              match_r[i*PORT + int'(acc_out[i])]         <= 1'b1;
              match_pri_r[i*PRIORITY + int'(acc_pri[i])] <= 1'b1;
              in_matched[i]           <= 1'b1;
              out_matched[acc_out[i]] <= 1'b1;
              // Pointers move only on first-iteration accepts to keep iSLIP desynchronisation.
              if (iter_cnt == IT_W'(1)) begin
                g_ptr[acc_out[i]][acc_pri[i]] <= PTR_W'(i + 1);
                a_ptr[i][acc_pri[i]]          <= acc_out[i] + PTR_W'(1);
              end
            end
          end
          if (state_d == GRANT) iter_cnt <= iter_cnt + IT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_match     = match_r;
  assign o_match_pri = match_pri_r;

`ifdef P_ISLIP_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] slot_cnt_r, match_cnt_r;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [PORT*PORT-1:0] v);
    popcount = '0;
    for (int k = 0; k < PORT*PORT; k++)
      if (v[k]) popcount = popcount + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_r  <= '0;
      match_cnt_r <= '0;
    end else if (state_q == DONE) begin
      slot_cnt_r  <= slot_cnt_r + CNT_WIDTH'(1);
      match_cnt_r <= match_cnt_r + popcount(match_r);
    end
  end

  assign o_slot_cnt  = slot_cnt_r;
  assign o_match_cnt = match_cnt_r;
`else
  assign o_slot_cnt  = '0;
  assign o_match_cnt = '0;
`endif

endmodule

// File: tb/tb_p_islip_scheduler.sv
// Directed self-checking bench for p_islip_scheduler (latency, matches, pointers,
// priority, multi-iteration, ignored start, mid-slot reset, optional statistics).
module tb_p_islip_scheduler;

  localparam int PORT      = 8;
  localparam int PRIORITY  = 4;
  localparam int ITER      = 2;
  localparam int CNT_WIDTH = 32;
  localparam int REQ_W     = PORT * PORT * PRIORITY;

  logic                       clk;
  logic                       rst;
  logic                       i_start;
  logic [REQ_W-1:0]           i_voq_req;
  logic                       o_busy;
  logic                       o_valid;
  logic [PORT*PORT-1:0]       o_match;
  logic [PORT*PRIORITY-1:0]   o_match_pri;
  logic [CNT_WIDTH-1:0]       o_match_cnt;
  logic [CNT_WIDTH-1:0]       o_slot_cnt;

  int checks = 0;
  int errors = 0;

  p_islip_scheduler #(
    .PORT(PORT), .PRIORITY(PRIORITY), .ITER(ITER), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_voq_req(i_voq_req),
    .o_busy(o_busy), .o_valid(o_valid), .o_match(o_match),
    .o_match_pri(o_match_pri), .o_match_cnt(o_match_cnt), .o_slot_cnt(o_slot_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int bidx(input int in, input int out, input int p);
    return (in * PORT + out) * PRIORITY + p;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after o_valid. lat = negedges after start edge.
  task automatic run_slot(input logic [REQ_W-1:0] req, input bit glitch, output int lat);
    lat       = 0;
    i_voq_req = req;
    i_start   = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (glitch && n == 2) begin
        i_start   = 1'b1;
        i_voq_req = '1;
      end else begin
        i_start = 1'b0;
      end
      if (o_valid) begin
        lat = n;
        check("busy_at_valid", 64'(o_busy), 64'd1);
        break;
      end
    end
    i_start = 1'b0;
    if (lat == 0) check("valid_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("valid_pulse", 64'(o_valid), 64'd0);
    check("busy_drop", 64'(o_busy), 64'd0);
  endtask

  logic [REQ_W-1:0] req;
  int               lat;
  bit               seen;

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_voq_req = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_match", o_match, 64'd0);
    check("rst_pri", 64'(o_match_pri), 64'd0);
    check("rst_slot_cnt", 64'(o_slot_cnt), 64'd0);
    check("rst_match_cnt", 64'(o_match_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request VOQ(0,3,p2): matched in iteration 1, empty iteration 2.
    req = '0;
    req[bidx(0, 3, 2)] = 1'b1;
    run_slot(req, 1'b0, lat);
    check("single_lat", 64'(lat), 64'd5);
    check("single_match", o_match, 64'h8);
    check("single_pri", 64'(o_match_pri), 64'h4);
    check("single_gptr", 64'(dut.g_ptr[3][2]), 64'd1);
    check("single_aptr", 64'(dut.a_ptr[0][2]), 64'd4);
    @(negedge clk);
    check("match_hold", o_match, 64'h8);

    // No requests: one empty iteration.
    run_slot('0, 1'b0, lat);
    check("zero_lat", 64'(lat), 64'd3);
    check("zero_match", o_match, 64'd0);
    check("zero_pri", 64'(o_match_pri), 64'd0);

    // Round-robin fairness on out0 at p0, back-to-back slots.
    do_reset();
    req = '0;
    req[bidx(0, 0, 0)] = 1'b1;
    req[bidx(1, 0, 0)] = 1'b1;
    req[bidx(2, 0, 0)] = 1'b1;
    run_slot(req, 1'b0, lat);
    check("fair1_match", o_match, 64'h1);
    check("fair1_pri", 64'(o_match_pri), 64'h1);
    run_slot(req, 1'b0, lat);
    check("fair2_match", o_match, 64'h100);
    check("fair2_pri", 64'(o_match_pri), 64'h10);
    run_slot(req, 1'b0, lat);
    check("fair3_match", o_match, 64'h1_0000);
    check("fair3_pri", 64'(o_match_pri), 64'h100);
    check("fair_gptr", 64'(dut.g_ptr[0][0]), 64'd3);
`ifdef P_ISLIP_SCHED_STATS_EN
    check("stats_slot", 64'(o_slot_cnt), 64'd3);
    check("stats_match", 64'(o_match_cnt), 64'd3);
`else
    check("stats_slot_off", 64'(o_slot_cnt), 64'd0);
    check("stats_match_off", 64'(o_match_cnt), 64'd0);
`endif

    // Priority: p0 request from in1 beats p3 request from in0 on out0.
    do_reset();
    req = '0;
    req[bidx(0, 0, 3)] = 1'b1;
    req[bidx(1, 0, 0)] = 1'b1;
    run_slot(req, 1'b0, lat);
    check("prio_lat", 64'(lat), 64'd5);
    check("prio_match", o_match, 64'h100);
    check("prio_pri", 64'(o_match_pri), 64'h10);
    check("prio_gptr_p3", 64'(dut.g_ptr[0][3]), 64'd0);
    check("prio_gptr_p0", 64'(dut.g_ptr[0][0]), 64'd2);

    // Second iteration picks up in1->out1; no pointer movement for it.
    do_reset();
    req = '0;
    req[bidx(0, 0, 0)] = 1'b1;
    req[bidx(0, 1, 0)] = 1'b1;
    req[bidx(1, 1, 0)] = 1'b1;
    run_slot(req, 1'b0, lat);
    check("iter2_lat", 64'(lat), 64'd5);
    check("iter2_match", o_match, 64'h201);
    check("iter2_pri", 64'(o_match_pri), 64'h11);
    check("iter2_gptr1", 64'(dut.g_ptr[1][0]), 64'd0);
    check("iter2_aptr1", 64'(dut.a_ptr[1][0]), 64'd0);
    check("iter2_gptr0", 64'(dut.g_ptr[0][0]), 64'd1);
    check("iter2_aptr0", 64'(dut.a_ptr[0][0]), 64'd1);

    // i_start while busy (with all-ones requests) must not disturb the slot.
    req = '0;
    req[bidx(2, 5, 1)] = 1'b1;
    run_slot(req, 1'b1, lat);
    check("glitch_lat", 64'(lat), 64'd5);
    check("glitch_match", o_match, 64'h20_0000);
    check("glitch_pri", 64'(o_match_pri), 64'h200);
    repeat (3) @(negedge clk);
    check("glitch_idle", 64'(o_busy), 64'd0);

    // Reset two edges into a slot: no o_valid, pointers back to zero.
    req = '0;
    req[bidx(0, 3, 2)] = 1'b1;
    i_voq_req = req;
    i_start   = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_match", o_match, 64'd0);
    check("midrst_gptr", 64'(dut.g_ptr[3][2]), 64'd0);
    check("midrst_aptr", 64'(dut.a_ptr[0][2]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
